// File: rtl/ss_serializer.sv
// ss_serializer
//   Parallel-to-serial code sender. A WIDTH-bit code word is accepted through
//   a valid/ready handshake and shifted out MSB-first on `out`, each bit held
//   for DIV clocks. Between frames `out` sits at IDLE_BIT.
//
// Parameters
//   WIDTH    code word length in bits (2..16)
//   DIV      clocks each bit is held on `out` (1..255)
//   IDLE_BIT level driven on `out` when no frame is active
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   load_data   code word, sampled only on an accepted handshake
//   load_valid  requester offers load_data
//   load_ready  block can accept a word (state == IDLE)
//   out         serial bit stream (registered)
//   busy        frame being shifted (state == SHIFT)
//   bit_strobe  one-cycle pulse on the first cycle each new bit is on `out`
//   done        one-cycle pulse in the first IDLE cycle after a frame
module ss_serializer #(
  parameter int   WIDTH    = 4,
  parameter int   DIV      = 1,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             busy,
  output logic             bit_strobe,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = ($clog2(DIV + 1) > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    bit_cnt, bit_cnt_next;
  logic [DW-1:0]    div_cnt, div_cnt_next;
  logic             out_next;
  logic             bit_strobe_next;
  logic             done_next;

  // State and datapath registers; reset clears everything asynchronously so
  // an aborted frame leaves `out` at the idle level without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      out        <= IDLE_BIT;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      bit_cnt    <= bit_cnt_next;
      div_cnt    <= div_cnt_next;
      out        <= out_next;
      bit_strobe <= bit_strobe_next;
      done       <= done_next;
    end
  end

  always_comb begin
    state_next      = state;
    sr_next         = sr;
    bit_cnt_next    = bit_cnt;
    div_cnt_next    = div_cnt;
    out_next        = out;
    bit_strobe_next = 1'b0;
    done_next       = 1'b0;

    unique case (state)
      IDLE: begin
        out_next = IDLE_BIT;
        if (load_valid) begin
          // The MSB goes straight to `out`; sr keeps the remaining bits
          // left-aligned so sr[WIDTH-1] is always the next bit to send.
          sr_next         = {load_data[WIDTH-2:0], 1'b0};
          out_next        = load_data[WIDTH-1];
          bit_cnt_next    = LAST_BIT;
          div_cnt_next    = DIV_RELOAD;
          bit_strobe_next = 1'b1;
          state_next      = SHIFT;
        end
      end

      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_next = div_cnt - 1'b1;
        end else if (bit_cnt != '0) begin
          out_next        = sr[WIDTH-1];
          sr_next         = {sr[WIDTH-2:0], 1'b0};
          bit_cnt_next    = bit_cnt - 1'b1;
          div_cnt_next    = DIV_RELOAD;
          bit_strobe_next = 1'b1;
        end else begin
          // Last bit has been held for its full DIV clocks.
          out_next   = IDLE_BIT;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        out_next   = IDLE_BIT;
      end
    endcase
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT);

endmodule

// File: tb/tb_ss_serializer.sv
// Testbench for ss_serializer. Three instances share one clock:
//   u0: WIDTH=4, DIV=1   u1: WIDTH=4, DIV=3   u2: WIDTH=4, DIV=2
// Each observation is packed as {out, bit_strobe, done, busy, load_ready}.
module tb_ss_serializer;

  localparam logic [4:0] IDLE_OBS = 5'b10001;
  localparam logic [4:0] DONE_OBS = 5'b10101;

  logic       clk = 1'b0;
  logic [2:0] rn;
  logic [2:0] lv;
  logic [3:0] ld0, ld1, ld2;
  logic [2:0] rdy, so, bsy, stb, dn;

  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ss_serializer #(.WIDTH(4), .DIV(1), .IDLE_BIT(1'b1)) u0 (
    .clock(clk), .reset(rn[0]), .load_data(ld0), .load_valid(lv[0]),
    .load_ready(rdy[0]), .out(so[0]), .busy(bsy[0]), .bit_strobe(stb[0]), .done(dn[0])
  );
  ss_serializer #(.WIDTH(4), .DIV(3), .IDLE_BIT(1'b1)) u1 (
    .clock(clk), .reset(rn[1]), .load_data(ld1), .load_valid(lv[1]),
    .load_ready(rdy[1]), .out(so[1]), .busy(bsy[1]), .bit_strobe(stb[1]), .done(dn[1])
  );
  ss_serializer #(.WIDTH(4), .DIV(2), .IDLE_BIT(1'b1)) u2 (
    .clock(clk), .reset(rn[2]), .load_data(ld2), .load_valid(lv[2]),
    .load_ready(rdy[2]), .out(so[2]), .busy(bsy[2]), .bit_strobe(stb[2]), .done(dn[2])
  );

  function automatic logic [4:0] obs(input int i);
    return {so[i], stb[i], dn[i], bsy[i], rdy[i]};
  endfunction

  // Expected per-cycle observations for one frame starting the cycle after
  // acceptance, followed by the done cycle.
  task automatic push_frame(input logic [3:0] w, input int div);
    for (int c = 0; c < 4 * div; c++) begin
      exp_q.push_back({w[3 - c / div], ((c % div) == 0), 1'b0, 1'b1, 1'b0});
    end
    exp_q.push_back(DONE_OBS);
  endtask

  task automatic test_reset;
    logic [4:0] got;
    rn  = 3'b000;
    lv  = 3'b001;
    ld0 = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = obs(0);
      checks++;
      if (got !== IDLE_OBS) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", c, got, IDLE_OBS);
      end else $display("ok reset_hold cycle %0d: %b", c, got);
    end
    lv = 3'b000;
    rn = 3'b111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      got = obs(0);
      checks++;
      if (got !== IDLE_OBS) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", c, got, IDLE_OBS);
      end else $display("ok reset_release cycle %0d: %b", c, got);
    end
  endtask

  task automatic test_div1;
    logic [4:0] got, exp;
    int c;
    @(negedge clk);
    ld0 = 4'b0110;
    lv[0] = 1'b1;
    push_frame(4'b0110, 1);
    exp_q.push_back(IDLE_OBS);
    @(posedge clk);
    #1 lv[0] = 1'b0;
    c = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = obs(0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div1_0110 cycle %0d: got %b expected %b", c, got, exp);
      end else $display("ok div1_0110 cycle %0d: %b", c, got);
      c++;
    end
  endtask

  task automatic test_div3;
    logic [4:0] got, exp;
    int c;
    @(negedge clk);
    ld1 = 4'b1010;
    lv[1] = 1'b1;
    push_frame(4'b1010, 3);
    exp_q.push_back(IDLE_OBS);
    @(posedge clk);
    #1 lv[1] = 1'b0;
    c = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = obs(1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div3_1010 cycle %0d: got %b expected %b", c, got, exp);
      end else $display("ok div3_1010 cycle %0d: %b", c, got);
      c++;
    end
  endtask

  // load_valid held high: 0110 accepted, junk 1111 offered while busy,
  // 1001 presented before the idle cycle and accepted right after it.
  task automatic test_back_to_back;
    logic [4:0] got, exp;
    @(negedge clk);
    ld0 = 4'b0110;
    lv[0] = 1'b1;
    push_frame(4'b0110, 1);
    push_frame(4'b1001, 1);
    exp_q.push_back(IDLE_OBS);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) ld0 = 4'b1111;
      if (c == 4) ld0 = 4'b1001;
      if (c == 6) lv[0] = 1'b0;
      @(negedge clk);
      exp = exp_q.pop_front();
      got = obs(0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, got, exp);
      end else $display("ok back_to_back cycle %0d: %b", c, got);
    end
  endtask

  task automatic test_reset_midframe;
    logic [4:0] got, exp;
    @(negedge clk);
    ld2 = 4'b1010;
    lv[2] = 1'b1;
    push_frame(4'b1010, 2);
    @(posedge clk);
    #1 lv[2] = 1'b0;
    // Cycles 1-3: MSB held two clocks, then bit 2 begins.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = obs(2);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midframe_pre cycle %0d: got %b expected %b", c, got, exp);
      end else $display("ok midframe_pre cycle %0d: %b", c, got);
    end
    exp_q.delete();
    #1 rn[2] = 1'b0;
    #1;
    got = obs(2);
    checks++;
    if (got !== IDLE_OBS) begin
      errors++;
      $display("FAIL midframe_async_reset: got %b expected %b", got, IDLE_OBS);
    end else $display("ok midframe_async_reset: %b", got);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) rn[2] = 1'b1;
      got = obs(2);
      checks++;
      if (got !== IDLE_OBS) begin
        errors++;
        $display("FAIL midframe_no_done cycle %0d: got %b expected %b", c, got, IDLE_OBS);
      end else $display("ok midframe_no_done cycle %0d: %b", c, got);
    end
    ld2 = 4'b0011;
    lv[2] = 1'b1;
    push_frame(4'b0011, 2);
    exp_q.push_back(IDLE_OBS);
    @(posedge clk);
    #1 lv[2] = 1'b0;
    for (int c = 1; exp_q.size() > 0; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = obs(2);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midframe_reload_0011 cycle %0d: got %b expected %b", c, got, exp);
      end else $display("ok midframe_reload_0011 cycle %0d: %b", c, got);
    end
  endtask

  initial begin
    rn  = 3'b000;
    lv  = 3'b000;
    ld0 = 4'b0000;
    ld1 = 4'b0000;
    ld2 = 4'b0000;
    test_reset();
    test_div1();
    test_div3();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
